// File: rtl/pix_fetch_pkg.sv
// Shared types and helpers for the framebuffer pixel fetch path.
package pix_fetch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain
  } fetch_state_t;

  localparam int unsigned PIX_W    = 4;
  localparam int unsigned WORD_PIX = 16;
  localparam int unsigned MEM_AW   = 9;
  localparam int unsigned SEL_W    = $clog2(WORD_PIX);
  localparam int unsigned REQ_W    = MEM_AW + SEL_W;

  typedef struct packed {
    logic [MEM_AW-1:0] word;
    logic [SEL_W-1:0]  pixsel;
  } mem_req_t;

  // Split a (wrapped) pixel index into memory word and pixel-in-word select.
  function automatic mem_req_t split_pix(input logic [REQ_W-1:0] pix_idx);
    mem_req_t r;
    r.pixsel = pix_idx[SEL_W-1:0];
    r.word   = pix_idx[REQ_W-1:SEL_W];
    return r;
  endfunction

endpackage

// File: rtl/pix_fetch_fifo.sv
// First-word-fall-through pixel FIFO with synchronous flush and occupancy count.
module pix_fetch_fifo
  import pix_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [PIX_W-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [PIX_W-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [PIX_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_wr, do_rd;

  assign empty   = (count_q == '0);
  assign count   = count_q;
  // Head is forced to zero when empty so a read on empty never exposes stale data.
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  assign do_wr = wr_en && !flush && (count_q != (AW+1)'(DEPTH));
  assign do_rd = rd_en && !flush && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/pix_fetch.sv
// Line fetch initiator: issues one pixel request per cycle to external pixel memory
// under FIFO credit, and buffers returned pixels for the TMDS pipeline.
module pix_fetch
  import pix_fetch_pkg::*;
#(
  parameter int unsigned FB_W    = 128,
  parameter int unsigned FB_H    = 64,
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned DEPTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     line_start,
  input  logic [$clog2(FB_H)-1:0]  line_idx,
  output logic                     busy,
  output logic [7:0]               mem_addr,
  output logic                     mem_bank,
  output logic [3:0]               mem_pixsel,
  input  logic [3:0]               mem_pixel,
  output logic [3:0]               pix_out,
  output logic                     pix_empty,
  input  logic                     pix_rd,
  output logic                     underflow
);

  localparam int unsigned XW     = $clog2(FB_W);
  localparam int unsigned LW     = $clog2(FB_H);
  localparam int unsigned IW     = $clog2(MEM_LAT + 2);
  localparam int unsigned CW     = $clog2(DEPTH) + 1;
  localparam int unsigned CRW    = $clog2(DEPTH + MEM_LAT + 2) + 1;
  localparam logic [XW-1:0] XLast = XW'(FB_W - 1);

  fetch_state_t     state_q, state_d;
  logic [XW-1:0]    x_q, x_d, x_sel;
  logic [LW-1:0]    line_q, line_d, line_sel;
  mem_req_t         req_q, req_d;
  logic             req_valid_q, req_valid_d;
  logic [MEM_LAT-1:0] vpipe_q, vpipe_d;
  logic             busy_q, busy_d;
  logic             underflow_q, underflow_d;

  logic             issue, flush, credit_ok;
  logic [IW-1:0]    inflight;
  logic [CW-1:0]    fifo_count;
  logic [CRW-1:0]   outstanding;
  logic [LW+XW-1:0] pix_idx;

  assign mem_addr   = req_q.word[7:0];
  assign mem_bank   = req_q.word[8];
  assign mem_pixsel = req_q.pixsel;
  assign busy       = busy_q;
  assign underflow  = underflow_q;

  // Requests on the pins this cycle plus everything still travelling back.
  always_comb begin
    inflight = IW'(req_valid_q);
    for (int i = 0; i < int'(MEM_LAT); i++) begin
      inflight = inflight + IW'(vpipe_q[i]);
    end
  end

  assign outstanding = CRW'(fifo_count) + CRW'(inflight);
  assign credit_ok   = (outstanding < CRW'(DEPTH));

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    line_d      = line_q;
    req_d       = req_q;
    vpipe_d     = MEM_LAT'({vpipe_q, req_valid_q});
    underflow_d = underflow_q;
    issue       = 1'b0;
    flush       = 1'b0;
    line_sel    = line_q;
    x_sel       = x_q;

    if (pix_rd && pix_empty) begin
      underflow_d = 1'b1;
    end

    if (line_start) begin
      // A new line always restarts at x=0; any line in progress is abandoned.
      underflow_d = 1'b0;
      flush       = (state_q != StIdle);
      line_d      = line_idx;
      line_sel    = line_idx;
      x_sel       = '0;
      x_d         = XW'(1);
      issue       = 1'b1;
      vpipe_d     = '0;
      state_d     = StFetch;
    end else begin
      case (state_q)
        StFetch: begin
          if (credit_ok) begin
            issue = 1'b1;
            x_d   = x_q + XW'(1);
            if (x_q == XLast) begin
              state_d = StDrain;
            end
          end
        end
        StDrain: begin
          if (vpipe_d == '0) begin
            state_d = StIdle;
          end
        end
        default: ;
      endcase
    end

    req_valid_d = issue;
    pix_idx     = {line_sel, x_sel};
    if (issue) begin
      req_d = split_pix(REQ_W'(pix_idx));
    end
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      x_q         <= '0;
      line_q      <= '0;
      req_q       <= '0;
      req_valid_q <= 1'b0;
      vpipe_q     <= '0;
      busy_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      line_q      <= line_d;
      req_q       <= req_d;
      req_valid_q <= req_valid_d;
      vpipe_q     <= vpipe_d;
      busy_q      <= busy_d;
      underflow_q <= underflow_d;
    end
  end

  pix_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .wr_en   (vpipe_q[MEM_LAT-1]),
    .wr_data (mem_pixel),
    .rd_en   (pix_rd),
    .rd_data (pix_out),
    .empty   (pix_empty),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_pix_fetch.sv
// Directed + randomized bench for pix_fetch against a framebuffer-array reference model.
module tb_pix_fetch;

  localparam int unsigned FB_W    = 128;
  localparam int unsigned FB_H    = 64;
  localparam int unsigned MEM_LAT = 2;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned FB_PIX  = 512 * 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       line_start = 1'b0;
  logic [5:0] line_idx = '0;
  logic       busy;
  logic [7:0] mem_addr;
  logic       mem_bank;
  logic [3:0] mem_pixsel;
  logic [3:0] mem_pixel;
  logic [3:0] pix_out;
  logic       pix_empty;
  logic       pix_rd = 1'b0;
  logic       underflow;

  int checks = 0;
  int failures = 0;
  int pops = 0;
  logic exp_uf = 1'b0;
  logic [3:0] exp_q[$];
  logic [3:0] fb [FB_PIX];
  logic [3:0] hist [MEM_LAT];

  always #5 clk = ~clk;

  pix_fetch #(
    .FB_W    (FB_W),
    .FB_H    (FB_H),
    .MEM_LAT (MEM_LAT),
    .DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .line_start (line_start),
    .line_idx   (line_idx),
    .busy       (busy),
    .mem_addr   (mem_addr),
    .mem_bank   (mem_bank),
    .mem_pixsel (mem_pixsel),
    .mem_pixel  (mem_pixel),
    .pix_out    (pix_out),
    .pix_empty  (pix_empty),
    .pix_rd     (pix_rd),
    .underflow  (underflow)
  );

  // External memory: data for the request on the pins appears MEM_LAT cycles later.
  assign mem_pixel = hist[MEM_LAT-1];
  always @(posedge clk) begin
    hist[0] <= fb[{mem_bank, mem_addr, mem_pixsel}];
    for (int i = 1; i < int'(MEM_LAT); i++) hist[i] <= hist[i-1];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic int pix_of(input int l, input int x);
    return (l * FB_W + x) % FB_PIX;
  endfunction

  function automatic logic [31:0] pins();
    return 32'({mem_bank, mem_addr, mem_pixsel});
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"}, 32'(mem_addr), 0);
    chk({tag, "_bank"}, 32'(mem_bank), 0);
    chk({tag, "_pixsel"}, 32'(mem_pixsel), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_pix_out"}, 32'(pix_out), 0);
    chk({tag, "_empty"}, 32'(pix_empty), 1);
    chk({tag, "_underflow"}, 32'(underflow), 0);
  endtask

  // Pulse line_start for one cycle; returns at the middle of cycle 1.
  task automatic new_line(input int l);
    @(negedge clk);
    line_start = 1'b1;
    line_idx   = 6'(l);
    pix_rd     = 1'b0;
    exp_uf     = 1'b0;
    pops       = 0;
    exp_q.delete();
    for (int x = 0; x < int'(FB_W); x++) exp_q.push_back(fb[pix_of(l, x)]);
    @(negedge clk);
    line_start = 1'b0;
  endtask

  // One cycle of consumer behaviour; any pop taken at the next edge is checked here.
  task automatic cyc(input bit rd);
    pix_rd = rd;
    if (rd && !pix_empty) begin
      if (exp_q.size() == 0) begin
        chk("extra_pop", 32'(pix_out), 32'hdead);
      end else begin
        chk("pop_pixel", 32'(pix_out), 32'(exp_q.pop_front()));
      end
      pops++;
    end
    if (rd && pix_empty) exp_uf = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain_line(input int mode, input int budget);
    int n = 0;
    while ((busy || !pix_empty) && n < budget) begin
      cyc(mode == 1 ? 1'b1 : 1'($urandom_range(0, 1)));
      n++;
    end
    pix_rd = 1'b0;
    chk("drain_in_budget", 32'(n < budget), 1);
    chk("pixels_left", 32'(exp_q.size()), 0);
    chk("pop_count", 32'(pops), FB_W);
    chk("underflow_sticky", 32'(underflow), 32'(exp_uf));
  endtask

  initial begin
    int l;
    for (int i = 0; i < int'(FB_PIX); i++) fb[i] = 4'(i % 16);

    // Reset state
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Read on empty after reset
    pix_rd = 1'b1;
    @(negedge clk);
    pix_rd = 1'b0;
    chk("uf_set", 32'(underflow), 1);
    chk("uf_pix_out", 32'(pix_out), 0);
    chk("uf_empty", 32'(pix_empty), 1);

    // Line 0 with continuous reads: latency and line-completion timing
    new_line(0);
    chk("uf_cleared", 32'(underflow), 0);
    chk("l0_busy_rise", 32'(busy), 1);
    chk("l0_first_req", pins(), 0);
    for (int c = 1; c <= 140; c++) begin
      if (c == 2) chk("l0_second_req", pins(), 1);
      if (c == 3) chk("l0_empty_c3", 32'(pix_empty), 1);
      if (c == 4) chk("l0_empty_c4", 32'(pix_empty), 0);
      if (c == 130) chk("l0_busy_c130", 32'(busy), 1);
      if (c == 131) chk("l0_busy_c131", 32'(busy), 0);
      cyc(1'b1);
    end
    pix_rd = 1'b0;
    chk("l0_pixels_left", 32'(exp_q.size()), 0);
    chk("l0_pops", 32'(pops), FB_W);
    chk("l0_last_req", pins(), 32'h7f);

    for (int i = 0; i < int'(FB_PIX); i++) fb[i] = 4'($urandom);

    // Last line: address top of the 512-word space
    new_line(63);
    chk("l63_first_req", pins(), 32'h1f80);
    drain_line(0, 3000);
    chk("l63_last_req", pins(), 32'h1fff);

    // No consumer: credit stalls after DEPTH requests, then resumes
    l = int'($urandom_range(0, FB_H - 1));
    new_line(l);
    repeat (30) cyc(1'b0);
    chk("stall_not_empty", 32'(pix_empty), 0);
    chk("stall_busy", 32'(busy), 1);
    chk("stall_req", pins(), 32'(pix_of(l, DEPTH - 1)));
    cyc(1'b1);
    chk("resume_wait", pins(), 32'(pix_of(l, DEPTH - 1)));
    cyc(1'b1);
    chk("resume_req", pins(), 32'(pix_of(l, DEPTH)));
    drain_line(1, 3000);

    // Abort mid-line with requests in flight
    new_line(2);
    repeat (12) cyc(1'b1);
    new_line(5);
    chk("abort_empty", 32'(pix_empty), 1);
    chk("abort_busy", 32'(busy), 1);
    chk("abort_req", pins(), 32'h280);
    drain_line(0, 3000);

    // Random lines with random consumer
    for (int k = 0; k < 3; k++) begin
      new_line(int'($urandom_range(0, FB_H - 1)));
      drain_line(0, 3000);
    end

    // Asynchronous reset in the middle of a line
    new_line(7);
    repeat (20) cyc(1'($urandom_range(0, 1)));
    #2;
    rst_n  = 1'b0;
    pix_rd = 1'b0;
    #1;
    chk_reset_vals("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    new_line(9);
    chk("post_reset_req", pins(), 32'(pix_of(9, 0)));
    drain_line(0, 3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
